// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
//   fetch_state_e : FETCH / HOLD / DRAIN state encoding
//   PIPE_*        : default widths, reset PC and NOP instruction
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam int          PIPE_ADDR_W   = 32;
    localparam int          PIPE_INST_W   = 32;
    localparam logic [31:0] PIPE_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PIPE_NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_reg.sv
// RegisterSynch: general-purpose register with synchronous reset.
//   clk : clock, rising edge
//   rst : synchronous reset, loads RST_VAL
//   clr : synchronous clear, loads RST_VAL (lower priority than rst)
//   ld  : load enable for d
//   d   : next value
//   q   : registered value
module RegisterSynch #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= RST_VAL;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, handshakes with a variable-latency instruction memory,
// applies branch redirects and downstream freeze.
//   CLK, RST            : clock, synchronous active-high reset
//   freeze              : hold delivered instruction, do not advance PC
//   branch_taken/addr   : one-cycle redirect (overrides freeze)
//   imem_req/addr       : fetch request; address stable until imem_ready
//   imem_ready/rdata    : memory response
//   pc_out              : delivered instruction address + 4
//   inst_out/inst_valid : delivered instruction (NOP_INST when not valid)
//   fsm_state           : current FSM state, for observation
//
// Handshake: a request is presented while imem_req=1 and completes in the
// first cycle with imem_ready=1 (possibly the same cycle). A request is never
// withdrawn; a branch while a request is pending moves to DRAIN, which keeps
// presenting the old address until the memory answers, then drops the data.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = PIPE_ADDR_W,
    parameter int                INST_W   = PIPE_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PIPE_RESET_PC),
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(PIPE_NOP_INST)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic [INST_W-1:0] inst_out,
    output logic              inst_valid,
    output logic [1:0]        fsm_state
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] drain_addr;
    logic [INST_W-1:0] hold_buf;
    logic              pc_ld;
    logic              drain_ld;
    logic              hold_ld;

    // Next-PC selection and register load enables.
    always_comb begin
        pc_inc    = pc + ADDR_W'(4);    // wraps modulo 2^ADDR_W
        br_target = {branch_addr[ADDR_W-1:2], 2'b00};
        pc_d      = pc_inc;
        pc_ld     = 1'b0;
        drain_ld  = 1'b0;
        hold_ld   = 1'b0;
        if (branch_taken) begin
            pc_d     = br_target;
            pc_ld    = 1'b1;
            // Remember the abandoned address so it stays on the bus.
            drain_ld = (state == FETCH) && !imem_ready;
        end else begin
            case (state)
                FETCH: begin
                    pc_ld   = imem_ready && !freeze;
                    hold_ld = imem_ready && freeze;
                end
                HOLD:    pc_ld = !freeze;
                default: ;
            endcase
        end
    end

    RegisterSynch #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc_reg (
        .clk(CLK), .rst(RST), .clr(1'b0), .ld(pc_ld), .d(pc_d), .q(pc)
    );

    RegisterSynch #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_drain_reg (
        .clk(CLK), .rst(RST), .clr(1'b0), .ld(drain_ld), .d(pc), .q(drain_addr)
    );

    // A flush empties the hold buffer back to NOP.
    RegisterSynch #(.W(INST_W), .RST_VAL(NOP_INST)) u_hold_reg (
        .clk(CLK), .rst(RST), .clr(branch_taken), .ld(hold_ld), .d(imem_rdata), .q(hold_buf)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (branch_taken) begin
                        state <= imem_ready ? FETCH : DRAIN;
                    end else if (imem_ready && freeze) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (branch_taken || !freeze) begin
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    // A branch here only retargets pc; the outstanding
                    // request still has to complete before fetching resumes.
                    if (imem_ready) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req   = 1'b1;
        imem_addr  = pc;
        inst_valid = 1'b0;
        inst_out   = NOP_INST;
        pc_out     = pc_inc;
        case (state)
            FETCH: begin
                inst_valid = imem_ready && !branch_taken;
                if (inst_valid) begin
                    inst_out = imem_rdata;
                end
            end
            HOLD: begin
                imem_req   = 1'b0;
                inst_valid = !branch_taken;
                if (inst_valid) begin
                    inst_out = hold_buf;
                end
            end
            DRAIN:   imem_addr = drain_addr;
            default: ;
        endcase
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [31:0] G   = 32'hDEAD_BEEF;   // garbage read data
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [1:0]  SF  = 2'd0;
    localparam logic [1:0]  SH  = 2'd1;
    localparam logic [1:0]  SD  = 2'd2;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic [1:0]  fsm_state;

    if_fetch_unit dut (
        .CLK(clk), .RST(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc_out(pc_out),
        .inst_out(inst_out), .inst_valid(inst_valid), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fr;
        logic        br;
        logic [31:0] ba;
        logic        rdy;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [1:0]  e_st;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];   // {pc_out, inst_out} for every delivered instruction
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic add(input logic r, input logic fr, input logic br, input logic [31:0] ba,
                       input logic rdy, input logic [31:0] rd, input logic e_req,
                       input logic [31:0] e_addr, input logic e_vld, input logic [31:0] e_inst,
                       input logic [31:0] e_pc, input logic [1:0] e_st);
        vec_t v;
        v.rst = r; v.fr = fr; v.br = br; v.ba = ba; v.rdy = rdy; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_inst = e_inst;
        v.e_pc = e_pc; v.e_st = e_st;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    // driver: apply one vector's inputs
    task automatic drive(input vec_t v);
        rst          = v.rst;
        freeze       = v.fr;
        branch_taken = v.br;
        branch_addr  = v.ba;
        imem_ready   = v.rdy;
        imem_rdata   = v.rd;
    endtask

    initial begin
        logic [63:0] got;
        // rst fr br ba  rdy rd  | req addr vld inst pc_out state
        // first cycle after reset, memory not yet answering
        add(0,0,0,0, 0,G,          1,32'h00,0,NOP,         32'h04,SF);
        // zero-wait streaming
        add(0,0,0,0, 1,w(32'h00),  1,32'h00,1,w(32'h00),   32'h04,SF);
        add(0,0,0,0, 1,w(32'h04),  1,32'h04,1,w(32'h04),   32'h08,SF);
        add(0,0,0,0, 1,w(32'h08),  1,32'h08,1,w(32'h08),   32'h0C,SF);
        add(0,0,0,0, 1,w(32'h0C),  1,32'h0C,1,w(32'h0C),   32'h10,SF);
        // three-cycle latency at 0x10
        add(0,0,0,0, 0,G,          1,32'h10,0,NOP,         32'h14,SF);
        add(0,0,0,0, 0,G,          1,32'h10,0,NOP,         32'h14,SF);
        add(0,0,0,0, 1,w(32'h10),  1,32'h10,1,w(32'h10),   32'h14,SF);
        add(0,0,0,0, 1,w(32'h14),  1,32'h14,1,w(32'h14),   32'h18,SF);
        add(0,0,0,0, 1,w(32'h18),  1,32'h18,1,w(32'h18),   32'h1C,SF);
        add(0,0,0,0, 1,w(32'h1C),  1,32'h1C,1,w(32'h1C),   32'h20,SF);
        // freeze at 0x20: capture, hold two cycles, release
        add(0,1,0,0, 1,w(32'h20),  1,32'h20,1,w(32'h20),   32'h24,SF);
        add(0,1,0,0, 1,G,          0,32'h00,1,w(32'h20),   32'h24,SH);
        add(0,0,0,0, 0,G,          0,32'h00,1,w(32'h20),   32'h24,SH);
        // freeze while waiting has no effect
        add(0,1,0,0, 0,G,          1,32'h24,0,NOP,         32'h28,SF);
        // branch + freeze + ready: no HOLD, pc -> 0x40
        add(0,1,1,32'h42, 1,w(32'h24), 1,32'h24,0,NOP,     32'h28,SF);
        add(0,0,0,0, 0,G,          1,32'h40,0,NOP,         32'h44,SF);
        // branch to 0x103 while 0x40 is pending -> DRAIN
        add(0,0,1,32'h103, 0,G,    1,32'h40,0,NOP,         32'h44,SF);
        add(0,0,0,0, 0,G,          1,32'h40,0,NOP,         32'h104,SD);
        add(0,0,0,0, 1,w(32'h40),  1,32'h40,0,NOP,         32'h104,SD);
        add(0,0,0,0, 1,w(32'h100), 1,32'h100,1,w(32'h100), 32'h104,SF);
        // branch toward 0xFFFF_FFFC via DRAIN, with retargets inside DRAIN
        add(0,0,1,32'hFFFF_FFFF, 0,G, 1,32'h104,0,NOP,     32'h108,SF);
        add(0,1,1,32'h200, 0,G,    1,32'h104,0,NOP,        32'h0,SD);
        add(0,0,1,32'hFFFF_FFFC, 0,G, 1,32'h104,0,NOP,     32'h204,SD);
        add(0,0,0,0, 1,w(32'h104), 1,32'h104,0,NOP,        32'h0,SD);
        // fetch at top of address space: pc_out wraps to 0
        add(0,0,0,0, 1,w(32'hFFFF_FFFC), 1,32'hFFFF_FFFC,1,w(32'hFFFF_FFFC), 32'h0,SF);
        // enter DRAIN again, then reset inside DRAIN
        add(0,0,1,32'h80, 0,G,     1,32'h00,0,NOP,         32'h04,SF);
        add(1,0,0,0, 0,G,          1,32'h00,0,NOP,         32'h84,SD);
        add(0,0,0,0, 0,G,          1,32'h00,0,NOP,         32'h04,SF);
        add(0,0,0,0, 1,w(32'h00),  1,32'h00,1,w(32'h00),   32'h04,SF);

        // reset
        drive('{rst:1, fr:0, br:0, ba:0, rdy:0, rd:G, e_req:0, e_addr:0, e_vld:0, e_inst:0, e_pc:0, e_st:0});
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            if (vecs[i].e_vld) exp_q.push_back({vecs[i].e_pc, vecs[i].e_inst});
            @(negedge clk);
            chk("imem_req",   i, 32'(imem_req),   32'(vecs[i].e_req));
            if (vecs[i].e_req) chk("imem_addr", i, imem_addr, vecs[i].e_addr);
            chk("inst_valid", i, 32'(inst_valid), 32'(vecs[i].e_vld));
            chk("inst_out",   i, inst_out,        vecs[i].e_inst);
            chk("pc_out",     i, pc_out,          vecs[i].e_pc);
            chk("state",      i, 32'(fsm_state),  32'(vecs[i].e_st));
            // scoreboard: every delivered instruction must match the oldest expectation
            if (inst_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected vec=%0d actual=%h_%h expected=none", i, pc_out, inst_out);
                end else begin
                    got = exp_q.pop_front();
                    if ({pc_out, inst_out} !== got) begin
                        failures++;
                        $display("FAIL sb_delivery vec=%0d actual=%h_%h expected=%h_%h",
                                 i, pc_out, inst_out, got[63:32], got[31:0]);
                    end
                end
            end
            @(posedge clk);
            #1;
        end

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_missing actual=%0d expected=0 pending deliveries", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
